dram_rmw_responder: RTL

//  Data-memory responder on the CPU's dram_* port, replacing the combinational data RAM.

---
 rtl/dram_pkg.sv | 29 ++
 rtl/dram_word_array.sv | 28 ++
 rtl/dram_rmw_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared types, widths and the byte-lane merge for the data-memory responder.
package dram_pkg;

    localparam int DRAM_AW = 32;
    localparam int DRAM_DW = 32;
    localparam int DRAM_MW = DRAM_DW / 8;

    localparam logic [DRAM_MW-1:0] FULL_MASK = '1;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_WR
    } state_t;

    // Lanes whose mask bit is set come from wdata, the rest keep the old word.
    function automatic logic [DRAM_DW-1:0] merge(
        input logic [DRAM_DW-1:0] old,
        input logic [DRAM_DW-1:0] wdata,
        input logic [DRAM_MW-1:0] mask
    );
        logic [DRAM_DW-1:0] bit_en;
        for (int i = 0; i < DRAM_MW; i++) begin
            bit_en[8*i +: 8] = {8{mask[i]}};
        end
        return (wdata & bit_en) | (old & ~bit_en);
    endfunction

endpackage

// File: rtl/dram_word_array.sv
// Single-port word RAM: synchronous read, whole-word write, read data held between reads.
module dram_word_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM macros; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dram_rmw_responder.sv
// CPU data-memory responder: range check, configurable-latency loads and
// read-modify-write partial stores over a word-wide single-port array.
module dram_rmw_responder
    import dram_pkg::*;
#(
    parameter int unsigned        DEPTH_WORDS = 1024,
    parameter logic [DRAM_AW-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned        RD_LAT      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dram_en,
    input  logic               dram_wen,
    input  logic [DRAM_AW-1:0] dram_addr,
    input  logic [DRAM_DW-1:0] dram_wdata,
    input  logic [DRAM_MW-1:0] dram_wmask,
    output logic [DRAM_DW-1:0] dram_rdata,
    output logic               dram_rvalid,
    output logic               dram_busy,
    output logic               dram_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DRAM_AW:0] SPAN = (DRAM_AW + 1)'(DEPTH_WORDS) << 2;
    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t             state;
    logic [1:0]         cnt;
    logic               busy_q;
    logic               rvalid_q;
    logic               err_q;
    logic               rd_oor_q;
    logic [DRAM_DW-1:0] rdata_hold;
    logic [DRAM_DW-1:0] wdata_q;
    logic [DRAM_MW-1:0] mask_q;
    logic [IDX_W-1:0]   idx_q;

    logic [DRAM_AW-1:0] offset;
    logic [IDX_W-1:0]   req_idx;
    logic               in_range;
    logic               accept;
    logic               is_full;
    logic               is_partial;
    logic [DRAM_DW-1:0] rdata_now;

    logic               ram_en;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [DRAM_DW-1:0] ram_wdata;
    logic [DRAM_DW-1:0] ram_rdata;

    // Subtracting first keeps the upper bound exact even when BASE_ADDR+span would overflow 32 bits.
    assign offset     = dram_addr - BASE_ADDR;
    assign in_range   = (dram_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign req_idx    = offset[IDX_W+1:2];
    assign accept     = dram_en && !busy_q;
    assign is_full    = (dram_wmask == FULL_MASK);
    assign is_partial = (dram_wmask != '0) && !is_full;

    assign rdata_now   = rd_oor_q ? '0 : ram_rdata;
    assign dram_rdata  = rvalid_q ? rdata_now : rdata_hold;
    assign dram_rvalid = rvalid_q;
    assign dram_busy   = busy_q;
    assign dram_err    = err_q;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = req_idx;
        ram_wdata = dram_wdata;
        if (state == RMW_WR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_idx   = idx_q;
            ram_wdata = merge(ram_rdata, wdata_q, mask_q);
        end else if (accept && in_range) begin
            // Loads and partial stores read; full stores write directly; empty masks touch nothing.
            ram_en = !dram_wen || (dram_wmask != '0);
            ram_we = dram_wen && is_full;
        end
    end

    dram_word_array #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (DRAM_DW),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_oor_q   <= 1'b0;
            rdata_hold <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            if (rvalid_q) begin
                rdata_hold <= rdata_now;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        err_q <= !in_range;
                        if (!dram_wen) begin
                            rd_oor_q <= !in_range;
                            cnt      <= LAT_M1;
                            if (RD_LAT == 1) begin
                                rvalid_q <= 1'b1;
                            end else begin
                                state  <= RD_WAIT;
                                busy_q <= 1'b1;
                            end
                        end else if (in_range && is_partial) begin
                            state   <= RMW_WR;
                            busy_q  <= 1'b1;
                            wdata_q <= dram_wdata;
                            mask_q  <= dram_wmask;
                            idx_q   <= req_idx;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        rvalid_q <= 1'b1;
                    end
                end
                RMW_WR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
